load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit, one outstanding access, registered outputs.
// Optional macro LSU_RMW_EN: SB/SH become read-modify-write of the aligned word.
module load_store_unit #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_func3,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam int            CW       = $clog2(RD_LATENCY) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_LATENCY - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    func3_q, func3_d;
  logic [1:0]    lo_q, lo_d;
  logic          busy_q, busy_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [2:0]    mem_func3_q, mem_func3_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_re_q, mem_re_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
`ifdef LSU_RMW_EN
  logic          rmw_q, rmw_d;
  logic [15:0]   wdata_q, wdata_d;
`endif

  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] lo);
    logic e;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = lo[0];
      3'b010:  e = (lo != 2'b00);
      3'b100:  e = we;
      3'b101:  e = we | lo[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

`ifdef LSU_RMW_EN
  // Lane insertion into the word just read back; the write always goes out as a full word.
  function automatic logic [31:0] store_merge(input logic is_byte, input logic [1:0] lo,
                                              input logic [31:0] w, input logic [15:0] d);
    logic [31:0] r;
    r = w;
    if (is_byte) begin
      case (lo)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (lo[1]) begin
      r[31:16] = d;
    end else begin
      r[15:0] = d;
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    func3_d      = func3_q;
    lo_d         = lo_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_addr_d   = mem_addr_q;
    mem_func3_d  = mem_func3_q;
    mem_wdata_d  = mem_wdata_q;
`ifdef LSU_RMW_EN
    rmw_d        = rmw_q;
    wdata_d      = wdata_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          func3_d     = req_func3;
          lo_d        = req_addr[1:0];
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_func3_d = req_func3;
`ifdef LSU_RMW_EN
          rmw_d       = 1'b0;
          wdata_d     = req_wdata[15:0];
`endif
          if (access_err(req_we, req_func3, req_addr[1:0])) begin
            state_d      = S_RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else if (!req_we) begin
            state_d = S_RD;
`ifdef LSU_RMW_EN
          end else if (req_func3 != 3'b010) begin
            state_d     = S_RD;
            mem_func3_d = 3'b010;
            rmw_d       = 1'b1;
`endif
          end else begin
            state_d     = S_WR;
            mem_wdata_d = req_wdata;
          end
        end
      end
      S_RD: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d      = S_RESP;
          resp_rdata_d = load_extract(func3_q, lo_q, mem_rdata);
          resp_err_d   = 1'b0;
`ifdef LSU_RMW_EN
          if (rmw_q) begin
            state_d      = S_WR;
            resp_rdata_d = resp_rdata_q;
            resp_err_d   = resp_err_q;
            mem_wdata_d  = store_merge(func3_q == 3'b000, lo_q, mem_rdata, wdata_q);
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR: begin
        state_d      = S_RESP;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Strobes are registered from the next state so each lines up with its state cycle.
    busy_d       = (state_d != S_IDLE);
    mem_re_d     = (state_d == S_RD);
    mem_we_d     = (state_d == S_WR);
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      func3_q      <= 3'b000;
      lo_q         <= 2'b00;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_func3_q  <= 3'b010;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_wdata_q  <= 32'h0;
`ifdef LSU_RMW_EN
      rmw_q        <= 1'b0;
      wdata_q      <= 16'h0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      func3_q      <= func3_d;
      lo_q         <= lo_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_func3_q  <= mem_func3_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      mem_wdata_q  <= mem_wdata_d;
`ifdef LSU_RMW_EN
      rmw_q        <= rmw_d;
      wdata_q      <= wdata_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_func3  = mem_func3_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized bench for load_store_unit against a per-cycle expectation queue.
module tb_load_store_unit;
  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst, req, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_func3;
  logic        busy, resp_valid, resp_err, mem_we, mem_re;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_func3;

  always #5 clk = ~clk;

  load_store_unit #(.RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_func3(req_func3), .req_wdata(req_wdata), .busy(busy), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr), .mem_func3(mem_func3),
    .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        busy, re, we, rv, err, chk_addr;
    logic [31:0] rdata, addr, wdata;
    logic [2:0]  f3;
  } exp_t;
  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  logic [31:0] mem [16];
  exp_t        exp_q[$];
  rd_t         rd_q[$];
  int          vectors = 0, miscompares = 0, cyc = 0, re_cnt = 0, we_cnt = 0;
  logic [31:0] last_wdata = 32'h0, cur_rdata = 32'h0;
  logic        cur_err = 1'b0, chk_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h at t=%0t", name, got, want, $time);
    end
  endtask

  // Memory: read data appears RD_LAT cycles after the mem_re cycle; random junk otherwise.
  always @(posedge clk) begin
    rd_t r;
    if (mem_re) rd_q.push_back('{cyc + RD_LAT, mem[mem_addr[5:2]]});
    if (mem_we && mem_func3 == 3'b010) mem[mem_addr[5:2]] = mem_wdata;
    cyc++;
    #1;
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      r = rd_q.pop_front();
      mem_rdata = r.data;
    end else begin
      mem_rdata = $urandom();
    end
  end

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    sz = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    int sh;
    logic [31:0] v;
    sh = 8 * int'(a % 4);
    v = w >> sh;
    case (f3)
      3'd0:    return (v & 32'hFF) | (((v & 32'h80) != 0) ? 32'hFFFF_FF00 : 32'h0);
      3'd4:    return v & 32'hFF;
      3'd1:    return (v & 32'hFFFF) | (((v & 32'h8000) != 0) ? 32'hFFFF_0000 : 32'h0);
      3'd5:    return v & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] w, input logic [31:0] d);
    int sh;
    logic [31:0] mask;
    sh = 8 * int'(a % 4);
    mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e.busy = 0; e.re = 0; e.we = 0; e.rv = 0; e.chk_addr = 0;
    e.err = cur_err; e.rdata = cur_rdata;
    e.addr = 0; e.wdata = 0; e.f3 = 0;
    return e;
  endfunction

  task automatic build_exp(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    exp_t e;
    logic [31:0] w;
    logic rmw;
    w = mem[a[5:2]];
    e = idle_exp();
    e.busy = 1;
    rmw = 1'b0;
`ifdef LSU_RMW_EN
    rmw = we && (f3 == 3'd0 || f3 == 3'd1);
`endif
    if (model_err(we, f3, a)) begin
      e.rv = 1; e.rdata = 0; e.err = 1;
      exp_q.push_back(e);
      cur_rdata = 0; cur_err = 1;
      return;
    end
    if (!we || rmw) begin
      e.re = 1; e.chk_addr = 1; e.addr = {a[31:2], 2'b00};
      exp_q.push_back(e);
      e.re = 0; e.chk_addr = 0;
      repeat (RD_LAT) exp_q.push_back(e);
    end
    if (we) begin
      e.we = 1; e.chk_addr = 1; e.addr = {a[31:2], 2'b00};
      e.f3 = rmw ? 3'b010 : f3;
      e.wdata = rmw ? model_merge(f3, a, w, wd) : wd;
      exp_q.push_back(e);
      e.we = 0; e.chk_addr = 0;
    end
    e.rv = 1; e.err = 0;
    e.rdata = we ? 32'h0 : model_load(f3, a, w);
    exp_q.push_back(e);
    cur_rdata = e.rdata; cur_err = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_exp();
      if (mem_re) re_cnt++;
      if (mem_we) begin
        we_cnt++;
        last_wdata = mem_wdata;
      end
      check32("ctrl{busy,re,we,valid,err}", {busy, mem_re, mem_we, resp_valid, resp_err},
              {e.busy, e.re, e.we, e.rv, e.err});
      check32("resp_rdata", resp_rdata, e.rdata);
      if (e.chk_addr) check32("mem_addr", mem_addr, e.addr);
      if (e.we) begin
        check32("mem_func3", mem_func3, e.f3);
        check32("mem_wdata", mem_wdata, e.wdata);
      end
    end
  end

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic noise,
                         output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    req = 1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
    #1;
    re_cnt = 0; we_cnt = 0;
    build_exp(we, f3, a, wd);
    @(posedge clk);
    #1;
    req = 0; req_we = $urandom; req_func3 = $urandom; req_addr = $urandom; req_wdata = $urandom;
    lat = -1; rd = 0; er = 0;
    for (int i = 1; i <= 8 + RD_LAT && lat < 0; i++) begin
      @(negedge clk);
      #1;
      if (resp_valid) begin
        lat = i; rd = resp_rdata; er = resp_err;
        req = 0;
      end else if (noise) begin
        req = $urandom_range(0, 1);
      end
    end
    if (lat < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL resp_timeout: got no resp_valid, required one within %0d cycles", 8 + RD_LAT);
      req = 0;
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] rd, a, wd;
    logic        er, we;
    logic [2:0]  f3;
    rst = 1; req = 0; req_we = 0; req_addr = 0; req_func3 = 0; req_wdata = 0; mem_rdata = 0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("reset_ctrl", {busy, resp_valid, resp_err, mem_we, mem_re, mem_func3}, 8'b0000_0010);
    check32("reset_rdata", resp_rdata, 32'h0);
    check32("reset_mem_addr", mem_addr, 32'h0);
    check32("reset_mem_wdata", mem_wdata, 32'h0);
    rst = 0; chk_en = 1;

    mem[4] = 32'h80FF_7F01;
    run_req(0, 3'b000, 32'h8000_0012, 0, 0, lat, rd, er);
    check32("lb_rdata", rd, 32'hFFFF_FFFF);
    check32("lb_latency", lat, 3);
    check32("lb_err", er, 0);
    run_req(0, 3'b101, 32'h8000_0012, 0, 0, lat, rd, er);
    check32("lhu_rdata", rd, 32'h0000_80FF);
    run_req(0, 3'b001, 32'h8000_0010, 0, 0, lat, rd, er);
    check32("lh_rdata", rd, 32'h0000_7F01);

    run_req(0, 3'b010, 32'h8000_0006, 0, 0, lat, rd, er);
    check32("lw_mis_latency", lat, 1);
    check32("lw_mis_err", er, 1);
    check32("lw_mis_rdata", rd, 32'h0);
    check32("lw_mis_strobes", re_cnt + we_cnt, 0);

    mem[4] = 32'h1122_3344;
    run_req(1, 3'b000, 32'h8000_0011, 32'h0000_00AB, 0, lat, rd, er);
`ifdef LSU_RMW_EN
    check32("sb_rmw_latency", lat, 4);
    check32("sb_rmw_wdata", last_wdata, 32'h1122_AB44);
    check32("sb_rmw_re_cnt", re_cnt, 1);
`else
    check32("sb_latency", lat, 2);
    check32("sb_wdata", last_wdata, 32'h0000_00AB);
    check32("sb_re_cnt", re_cnt, 0);
`endif
    check32("sb_we_cnt", we_cnt, 1);

    // Request held high through RESP: the second copy is taken only from IDLE.
    @(negedge clk);
    req = 1; req_we = 1; req_func3 = 3'b010; req_addr = 32'h8000_0014; req_wdata = 32'h0000_F00F;
    #1;
    re_cnt = 0; we_cnt = 0;
    build_exp(1, 3'b010, 32'h8000_0014, 32'h0000_F00F);
    exp_q.push_back(idle_exp());
    build_exp(1, 3'b010, 32'h8000_0014, 32'h0000_F00F);
    repeat (3) @(negedge clk);
    #1;
    check32("hold_we_cnt_first", we_cnt, 1);
    check32("hold_idle_busy", busy, 0);
    @(posedge clk);
    #1;
    req = 0;
    repeat (3) @(negedge clk);
    #1;
    check32("hold_we_cnt_total", we_cnt, 2);
    check32("hold_mem_word", mem[5], 32'h0000_F00F);

    // Reset during WAIT of a load aborts it.
    mem[2] = 32'hCAFE_0001;
    @(negedge clk);
    req = 1; req_we = 0; req_func3 = 3'b010; req_addr = 32'h8000_0008;
    #1;
    build_exp(0, 3'b010, 32'h8000_0008, 0);
    @(posedge clk);
    #1;
    req = 0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1;
    exp_q.delete();
    cur_rdata = 0; cur_err = 0;
    @(negedge clk);
    #1;
    check32("abort_busy_valid", {busy, resp_valid}, 2'b00);
    check32("abort_mem_func3", mem_func3, 3'b010);
    rst = 0;
    run_req(0, 3'b010, 32'h8000_0008, 0, 0, lat, rd, er);
    check32("after_abort_rdata", rd, 32'hCAFE_0001);
    check32("after_abort_latency", lat, 2 + RD_LAT);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) mem[$urandom_range(0, 15)] = $urandom;
      we = $urandom_range(0, 1);
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h8000_0000 | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 2) != 0) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 : {a[1], 1'b0};
      wd = $urandom;
      run_req(we, f3, a, wd, 1, lat, rd, er);
    end

    repeat (3) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
